// File: rtl/list_collector_if.sv
// Bundle between the list_collector, its upstream element stream and the list adder.
interface list_collector_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH     = 8
);
  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_last;
  logic                              in_ready;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] data_out;
  logic [$clog2(LENGTH+1)-1:0]       count_out;
  logic                              sum_en;
  logic                              sum_done;
  logic                              timeout_err;
  logic [15:0]                       list_count;

  modport master (
    output in_valid, in_data, in_last, sum_done,
    input  in_ready, data_out, count_out, sum_en, timeout_err, list_count
  );

  modport slave (
    input  in_valid, in_data, in_last, sum_done,
    output in_ready, data_out, count_out, sum_en, timeout_err, list_count
  );
endinterface

// File: rtl/list_collector.sv
// Packs a serial valid/ready element stream into a list for the adder, holds it
// with sum_en until sum_done (or a wait timeout), then releases for one cycle.
module list_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH     = 8,
  parameter int unsigned MAX_WAIT   = 64
) (
  input logic            clk,
  input logic            rst,
  list_collector_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(LENGTH);
  localparam int unsigned CNT_W  = $clog2(LENGTH + 1);
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(LENGTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                            state, state_next;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] slots, slots_next;
  logic [PTR_W-1:0]                  wr_ptr, ptr_next;
  logic [CNT_W-1:0]                  count, count_next;
  logic [WAIT_W-1:0]                 wait_q, wait_next;
  logic                              sum_en_q, sum_en_next;
  logic                              ready_q, ready_next;
  logic                              timeout_q, timeout_next;
  logic [15:0]                       lists, lists_next;

  // State and datapath registers; every output comes straight from one of these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      slots     <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wait_q    <= '0;
      sum_en_q  <= 1'b0;
      ready_q   <= 1'b1;
      timeout_q <= 1'b0;
      lists     <= '0;
    end else begin
      state     <= state_next;
      slots     <= slots_next;
      wr_ptr    <= ptr_next;
      count     <= count_next;
      wait_q    <= wait_next;
      sum_en_q  <= sum_en_next;
      ready_q   <= ready_next;
      timeout_q <= timeout_next;
      lists     <= lists_next;
    end
  end

  // Next-state and next-register values for FILL / HOLD / RELEASE.
  always_comb begin
    state_next   = state;
    slots_next   = slots;
    ptr_next     = wr_ptr;
    count_next   = count;
    sum_en_next  = sum_en_q;
    timeout_next = 1'b0;
    lists_next   = lists;
    wait_next    = '0;
    case (state)
      FILL: begin
        if (bus.in_valid && ready_q) begin
          slots_next[wr_ptr] = bus.in_data;
          count_next         = count + CNT_W'(1);
          if (wr_ptr == LAST_PTR || bus.in_last) begin
            state_next  = HOLD;
            sum_en_next = 1'b1;
          end else begin
            ptr_next = wr_ptr + PTR_W'(1);
          end
        end
      end
      HOLD: begin
        wait_next = wait_q + WAIT_W'(1);
        if (bus.sum_done || (MAX_WAIT != 0 && wait_q == WAIT_LIMIT)) begin
          // Buffer is cleared on the way into RELEASE so the release cycle already shows an empty list.
          state_next   = RELEASE;
          sum_en_next  = 1'b0;
          timeout_next = !bus.sum_done;
          lists_next   = lists + 16'd1;
          slots_next   = '0;
          ptr_next     = '0;
          count_next   = '0;
          wait_next    = '0;
        end
      end
      RELEASE: begin
        state_next = FILL;
      end
      default: begin
        state_next  = FILL;
        slots_next  = '0;
        ptr_next    = '0;
        count_next  = '0;
        sum_en_next = 1'b0;
      end
    endcase
    ready_next = (state_next == FILL);
  end

  assign bus.in_ready    = ready_q;
  assign bus.data_out    = slots;
  assign bus.count_out   = count;
  assign bus.sum_en      = sum_en_q;
  assign bus.timeout_err = timeout_q;
  assign bus.list_count  = lists;
endmodule

// File: tb/tb_list_collector.sv
// Self-checking bench for list_collector: directed scenarios plus a randomized
// stream with a responding adder, all compared against a list-level model.
module tb_list_collector;
  localparam int unsigned DW  = 32;
  localparam int unsigned LEN = 8;
  localparam int unsigned MW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  list_collector_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) bus ();

  list_collector #(.DATA_WIDTH(DW), .LENGTH(LEN), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // List-level model: collected elements, whether the list is being held,
  // how long it has been held, and whether this is the single release cycle.
  logic [DW-1:0] m_elems[$];
  bit            m_hold;
  bit            m_rel;
  bit            m_to;
  int unsigned   m_hold_cycles;
  int unsigned   m_lists;

  // Adder responder state for the randomized phase.
  int unsigned hold_seen = 0;
  int unsigned lat       = 1;
  bit          keep      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LEN-1:0][DW-1:0] model_vec();
    logic [LEN-1:0][DW-1:0] v;
    v = '0;
    for (int i = 0; i < m_elems.size(); i++) v[i] = m_elems[i];
    return v;
  endfunction

  function automatic logic [63:0] model_sum();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < m_elems.size(); i++) s += 64'(m_elems[i]);
    return s;
  endfunction

  // What the adder would compute from the presented vector.
  function automatic logic [63:0] slot_sum();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < LEN; i++) s += 64'(bus.data_out[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_elems.delete();
    m_hold        = 1'b0;
    m_rel         = 1'b0;
    m_to          = 1'b0;
    m_hold_cycles = 0;
    m_lists       = 0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (m_rel) begin
      m_rel = 1'b0;
    end else if (m_hold) begin
      m_hold_cycles++;
      if (bus.sum_done || (MW != 0 && m_hold_cycles == MW)) begin
        m_to   = !bus.sum_done;
        m_hold = 1'b0;
        m_rel  = 1'b1;
        m_lists++;
        m_elems.delete();
      end
    end else if (bus.in_valid) begin
      m_elems.push_back(bus.in_data);
      if (m_elems.size() == LEN || bus.in_last) begin
        m_hold        = 1'b1;
        m_hold_cycles = 0;
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    check("in_ready", 64'(bus.in_ready), 64'(!(m_hold || m_rel)));
    check("sum_en", 64'(bus.sum_en), 64'(m_hold));
    check("count_out", 64'(bus.count_out), 64'(m_elems.size()));
    check("timeout_err", 64'(bus.timeout_err), 64'(m_to));
    check("list_count", 64'(bus.list_count), 64'(m_lists[15:0]));
    checks++;
    if (bus.data_out !== model_vec()) begin
      errors++;
      $display("FAIL data_out: got %h expected %h at %0t", bus.data_out, model_vec(), $time);
    end
  end

  // One clock of directed stimulus; returns 1 time unit after the edge.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit sd);
    @(negedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.sum_done = sd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.sum_done = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, " sum_en"}, 64'(bus.sum_en), 64'd0);
    check({tag, " count_out"}, 64'(bus.count_out), 64'd0);
    check({tag, " list_count"}, 64'(bus.list_count), 64'd0);
    check({tag, " slot0"}, 64'(bus.data_out[0]), 64'd0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Single-element list, then six idle cycles with sum_done optionally on HOLD cycle 4.
  task automatic timeout_run(input bit collide, input int unsigned exp_to, input int unsigned exp_lists);
    int unsigned en_cnt;
    int unsigned to_cnt;
    drive(1'b1, 32'd9, 1'b1, 1'b0);
    en_cnt = 32'(bus.sum_en);
    to_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, '0, 1'b0, collide && k == 4);
      en_cnt += 32'(bus.sum_en);
      to_cnt += 32'(bus.timeout_err);
    end
    check("hold sum_en cycles", 64'(en_cnt), 64'd4);
    check("timeout pulses", 64'(to_cnt), 64'(exp_to));
    check("timeout list_count", 64'(bus.list_count), 64'(exp_lists));
    check("timeout reopen", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic rand_cycle();
    bit r;
    bit sd;
    @(negedge clk);
    #1;
    r = ($urandom_range(0, 299) == 0);
    if (bus.sum_en) begin
      hold_seen++;
      sd = (hold_seen == lat);
      if (sd) check("adder sum", slot_sum(), model_sum());
    end else begin
      hold_seen = 0;
      lat       = $urandom_range(1, 6);
      sd        = ($urandom_range(0, 7) == 0);
    end
    if (!keep) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = $urandom();
      bus.in_last  = ($urandom_range(0, 5) == 0);
    end
    keep = bus.in_valid && (m_hold || m_rel);
    bus.sum_done = sd;
    rst = r;
    if (r) begin
      model_reset();
      keep = 1'b0;
    end
    @(posedge clk);
    model_step();
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.sum_done = 1'b0;
    model_reset();
    @(posedge clk);
    model_step();
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset sum_en", 64'(bus.sum_en), 64'd0);
    check("reset count_out", 64'(bus.count_out), 64'd0);
    check("reset data_out", 64'(bus.data_out[LEN-1]), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;

    // Full list 1..8 back-to-back.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 7) check("full early sum_en", 64'(bus.sum_en), 64'd0);
    end
    check("full sum_en", 64'(bus.sum_en), 64'd1);
    check("full in_ready", 64'(bus.in_ready), 64'd0);
    check("full count_out", 64'(bus.count_out), 64'd8);
    check("full slot0", 64'(bus.data_out[0]), 64'd1);
    check("full slot7", 64'(bus.data_out[7]), 64'd8);
    check("full sum", slot_sum(), 64'd36);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("full release sum_en", 64'(bus.sum_en), 64'd0);
    check("full release in_ready", 64'(bus.in_ready), 64'd0);
    check("full list_count", 64'(bus.list_count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("full reopen", 64'(bus.in_ready), 64'd1);

    // Short list 5,6,7 terminated by in_last.
    drive(1'b1, 32'd5, 1'b0, 1'b0);
    drive(1'b1, 32'd6, 1'b0, 1'b0);
    drive(1'b1, 32'd7, 1'b1, 1'b0);
    check("short count_out", 64'(bus.count_out), 64'd3);
    check("short slot2", 64'(bus.data_out[2]), 64'd7);
    check("short slot3", 64'(bus.data_out[3]), 64'd0);
    check("short slot7", 64'(bus.data_out[7]), 64'd0);
    check("short sum", slot_sum(), 64'd18);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("short list_count", 64'(bus.list_count), 64'd2);

    // Timeout, then sum_done colliding with the last allowed HOLD cycle.
    timeout_run(1'b0, 1, 3);
    timeout_run(1'b1, 0, 4);

    // in_valid held through HOLD/RELEASE: element lands in slot 0 of the next list.
    drive(1'b1, 32'd3, 1'b1, 1'b0);
    drive(1'b1, 32'hAB, 1'b0, 1'b0);
    drive(1'b1, 32'hAB, 1'b0, 1'b1);
    drive(1'b1, 32'hAB, 1'b0, 1'b0);
    drive(1'b1, 32'hAB, 1'b0, 1'b0);
    check("held count_out", 64'(bus.count_out), 64'd1);
    check("held slot0", 64'(bus.data_out[0]), 64'hAB);
    check("held slot1", 64'(bus.data_out[1]), 64'd0);
    drive(1'b1, 32'd1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("held list_count", 64'(bus.list_count), 64'd6);

    // Reset mid-fill, then during HOLD.
    drive(1'b1, 32'd1, 1'b0, 1'b0);
    drive(1'b1, 32'd1, 1'b0, 1'b0);
    drive(1'b1, 32'd1, 1'b0, 1'b0);
    reset_pulse("rst fill");
    drive(1'b1, 32'd4, 1'b1, 1'b0);
    check("pre-rst sum_en", 64'(bus.sum_en), 64'd1);
    reset_pulse("rst hold");
    drive(1'b1, 32'd2, 1'b0, 1'b0);
    drive(1'b1, 32'd2, 1'b1, 1'b0);
    check("post-rst count_out", 64'(bus.count_out), 64'd2);
    check("post-rst slot0", 64'(bus.data_out[0]), 64'd2);
    check("post-rst slot1", 64'(bus.data_out[1]), 64'd2);
    check("post-rst slot2", 64'(bus.data_out[2]), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);

    // Randomized stream with a variable-latency adder and occasional resets.
    bus.in_valid = 1'b0;
    for (int n = 0; n < 3000; n++) rand_cycle();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
